// File: rtl/fifo_ram_fwft.sv
// First-word-fall-through FIFO: block RAM with registered read plus a prefetch
// output register that is the last storage slot, so rd_data is valid whenever !rd_empty.
module fifo_ram_fwft #(
    parameter  int DATA_WIDTH    = 32,
    parameter  int DATA_DEPTH    = 128,
    parameter  int PROG_FULL_TH  = DATA_DEPTH - 2,
    parameter  int PROG_EMPTY_TH = 2,
    localparam int CW            = $clog2(DATA_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_empty,
    output logic [CW-1:0]         rd_cnt,
    output logic                  prog_full,
    output logic                  prog_empty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int RD = DATA_DEPTH - 1;
    localparam int PW = (RD > 1) ? $clog2(RD) : 1;

    logic [DATA_WIDTH-1:0] r_mem [0:RD-1];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_ram_cnt, r_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_empty, r_ovf, r_unf;

    logic w_full, w_wr, w_rd, w_pf;

    assign w_full = (r_cnt == CW'(DATA_DEPTH));
    assign w_wr   = wr_en && !w_full;
    assign w_rd   = rd_en && !r_empty;
    // Refill the output register whenever it is empty or being drained this cycle.
    assign w_pf   = (r_ram_cnt != '0) && (r_empty || w_rd);

    always_ff @(posedge clk) begin
        if (rst_n && w_wr)
            r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ram_cnt <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_empty   <= 1'b1;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= (r_wr_ptr == PW'(DATA_DEPTH - 2)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pf) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DATA_DEPTH - 2)) ? '0 : r_rd_ptr + 1'b1;
                r_data   <= r_mem[r_rd_ptr];
                r_empty  <= 1'b0;
            end else if (w_rd) begin
                r_empty  <= 1'b1;
            end
            r_ram_cnt <= r_ram_cnt + CW'(w_wr) - CW'(w_pf);
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            // A fresh error in the clearing cycle keeps the flag set.
            r_ovf <= (r_ovf && !err_clr) || (wr_en && w_full);
            r_unf <= (r_unf && !err_clr) || (rd_en && r_empty);
        end
    end

    assign wr_full    = w_full;
    assign rd_data    = r_data;
    assign rd_empty   = r_empty;
    assign rd_cnt     = r_cnt;
    assign prog_full  = (r_cnt >= CW'(PROG_FULL_TH));
    assign prog_empty = (r_cnt <= CW'(PROG_EMPTY_TH));
    assign overflow   = r_ovf;
    assign underflow  = r_unf;

endmodule

// File: doc/fifo_ram_fwft.md
Name: fifo_ram_fwft

Overview:
Synchronous single-clock FIFO in first-word-fall-through (FWFT) mode, built on block RAM with a registered read port. It is the parametrised successor to the plain RAM FIFO. It adds a synchronous active-low reset, a prefetch output register, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. Montgomery/modexp datapath stages use it between producer and consumer with no extra read-latency handling.

Parameters:
DATA_WIDTH, 32, word width in bits (>=1)
DATA_DEPTH, 128, total capacity in words, RAM plus output register (>=2, need not be a power of two)
PROG_FULL_TH, DATA_DEPTH-2, prog_full asserts when occupancy >= this value (1..DATA_DEPTH)
PROG_EMPTY_TH, 2, prog_empty asserts when occupancy <= this value (0..DATA_DEPTH-1)
CW (derived), $clog2(DATA_DEPTH)+1, occupancy counter width

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write word
wr_full  out  1  occupancy == DATA_DEPTH
rd_en  in  1  pop request; rd_data is already valid whenever rd_empty=0
rd_data  out  DATA_WIDTH  head-of-FIFO word, registered
rd_empty  out  1  output register holds no valid word
rd_cnt  out  CW  occupancy, RAM words plus output register
prog_full  out  1  rd_cnt >= PROG_FULL_TH
prog_empty  out  1  rd_cnt <= PROG_EMPTY_TH
overflow  out  1  sticky: write attempted while wr_full
underflow  out  1  sticky: read attempted while rd_empty
err_clr  in  1  clears overflow/underflow

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - pointers, RAM count and rd_cnt go to 0; rd_data goes to 0.
  - rd_empty=1, wr_full=0, overflow=0, underflow=0.
  - prog_empty=1; prog_full=0.
  - RAM contents are not cleared.
  - Reset overrides any concurrent wr_en/rd_en. A reset mid-stream discards all data.
- Accepted write: wr_en & !wr_full, where wr_full is sampled at the start of the cycle. The word is stored at wr_ptr; wr_ptr advances, wrapping from DATA_DEPTH-2 to 0. The RAM holds DATA_DEPTH-1 entries; the output register is the last slot.
- Write while wr_full: dropped, no state change except overflow<=1. This holds even if rd_en is accepted in the same cycle; there is no write-through on full.
- Accepted read: rd_en & !rd_empty. The current rd_data is consumed.
- Read while rd_empty: ignored; underflow<=1.
- Prefetch:
  - Each cycle, if the RAM holds >=1 word and (output register empty or being consumed this cycle), the RAM is read at rd_ptr and rd_ptr advances with wrap.
  - rd_data loads mem[rd_ptr] at the same edge; rd_empty is then 0.
  - If the output register is consumed and the RAM is empty, rd_empty<=1 and rd_data holds its last value.
- Latency:
  - A word written into an empty FIFO at edge T appears on rd_data, with rd_empty=0, after edge T+1.
  - Back-to-back reads sustain one word per cycle with no bubbles once data is resident.
- Occupancy:
  - rd_cnt +1 on an accepted write only, -1 on an accepted read only, unchanged when both or neither are accepted.
  - rd_cnt counts the output register, so wr_full and rd_cnt reflect writes on the next cycle.
  - rd_empty can lag rd_cnt by one cycle after the first write.
  - rd_cnt never exceeds DATA_DEPTH and never goes below 0.
- Flags:
  - prog_full and prog_empty are combinational compares on the registered rd_cnt.
  - overflow/underflow are sticky until err_clr=1, which clears them at the edge.
  - A new error in the same cycle as err_clr wins: the flag ends at 1.
- Simultaneous rd/wr on an empty FIFO: the write is accepted, the read is an underflow, and rd_cnt ends at 1.
- Simultaneous rd/wr with 0<rd_cnt<DATA_DEPTH: both are accepted and rd_cnt is unchanged.
- Wrap-around with non-power-of-two depth must preserve order. Pointer compare is explicit against DATA_DEPTH-2.

Test Plan:
1. Reset/FWFT latency (DATA_WIDTH=16, DATA_DEPTH=8): release rst_n, write 0x1111 at edge T -> rd_empty=1 until edge T+1, then rd_data=0x1111, rd_cnt=1, prog_empty=1.
2. Fill/full/overflow: write 0x0001..0x0008 -> wr_full=1, rd_cnt=8, prog_full=1 (TH=6). Write 0x0009 -> overflow=1, rd_cnt stays 8. Read 8 words -> exactly 0x0001..0x0008 in order, then rd_empty=1.
3. Underflow and clear: rd_en on empty -> underflow=1, rd_cnt=0. Pulse err_clr -> underflow=0. Pulse err_clr together with another empty read -> underflow stays 1.
4. Streaming/wrap (DATA_DEPTH=6): continuous wr_en & rd_en for 50 cycles with an incrementing pattern after a 3-word preload -> output is in order with no bubbles and rd_cnt held at 3 throughout.
5. Full + simultaneous rd/wr: at rd_cnt=8, wr_en & rd_en in the same cycle -> read accepted, write dropped, overflow=1, rd_cnt=7.
6. Reset mid-operation: with rd_cnt=5, assert rst_n=0 for 1 cycle together with wr_en -> rd_cnt=0, rd_empty=1, rd_data=0, flags 0. The next written word 0xBEEF is the first word read.
